// File: rtl/request_enc_pkg.sv
// Shared constants, state encoding and mask helper for the request priority encoder.
package request_enc_pkg;

  localparam int N = 8;
  localparam int W = 3;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  function automatic logic [N-1:0] onehot(input logic [W-1:0] idx);
    logic [N-1:0] m;
    m      = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/eight_to_three_priority_encoder.sv
// Combinational 8:3 priority encoder; bit 7 wins, out is 0 when nothing is set.
module eight_to_three_priority_encoder
  import request_enc_pkg::*;
(
  input  logic [N-1:0] in,
  output logic [W-1:0] out,
  output logic         any
);

  // Ascending scan so the highest set index is the last one written.
  always_comb begin
    out = '0;
    for (int i = 0; i < N; i++) begin
      if (in[i]) out = W'(i);
    end
  end

  assign any = |in;

endmodule

// File: rtl/request_priority_encoder.sv
// Collects request lines into a pending vector and presents the highest one
// as a binary code with a valid/ack handshake.
//
//   state   | meaning
//   IDLE    | nothing pending, valid=0
//   PRESENT | code holds a pending request awaiting ack, valid=1
module request_priority_encoder
  import request_enc_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] req,
  input  logic         ack,
  output logic [W-1:0] code,
  output logic         valid,
  output logic [N-1:0] pend,
  output logic         drop
);

  state_t       state;
  logic [N-1:0] set;
  logic [N-1:0] clr;
  logic [N-1:0] pend_nxt;
  logic         drop_nxt;
  logic [W-1:0] enc_code;
  logic         pend_any;

  always_comb begin
    set      = req & {N{en}};
    clr      = (state == PRESENT && ack) ? onehot(code) : '0;
    // Set wins over clear so a held request is re-queued after its ack.
    pend_nxt = (pend & ~clr) | set;
    drop_nxt = |(set & pend & ~clr);
  end

  eight_to_three_priority_encoder u_prienc (
    .in  (pend_nxt),
    .out (enc_code),
    .any (pend_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      code  <= '0;
      pend  <= '0;
      drop  <= 1'b0;
    end else begin
      pend <= pend_nxt;
      drop <= drop_nxt;
      case (state)
        IDLE: begin
          if (pend_any) begin
            state <= PRESENT;
            code  <= enc_code;
          end
        end
        PRESENT: begin
          // No preemption: a new code is only loaded when the current one is acked.
          if (ack) begin
            if (pend_any) begin
              code <= enc_code;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign valid = (state == PRESENT);

endmodule

// File: tb/tb_request_priority_encoder.sv
// Directed-vector bench for request_priority_encoder with hand-computed expectations.
module tb_request_priority_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic       ack;
  logic [2:0] code;
  logic       valid;
  logic [7:0] pend;
  logic       drop;

  int n_vec = 0;
  int n_err = 0;

  request_priority_encoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .req   (req),
    .ack   (ack),
    .code  (code),
    .valid (valid),
    .pend  (pend),
    .drop  (drop)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [2:0] c,
                           input logic [7:0] p, input logic d);
    check_vec({tag, ".valid"}, 32'(valid), 32'(v));
    if (v) check_vec({tag, ".code"}, 32'(code), 32'(c));
    check_vec({tag, ".pend"}, 32'(pend), 32'(p));
    check_vec({tag, ".drop"}, 32'(drop), 32'(d));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en = 1'b1; req = 8'h00; ack = 1'b0;
    #12;
    check_vec("rst.code", 32'(code), 32'd0);
    check_out("rst", 1'b0, 3'd0, 8'h00, 1'b0);
    rst_n = 1'b1;
    tick();

    // 1: single pulse, one-cycle latency, ack clears
    req = 8'b0000_0100; tick(); req = 8'h00;
    check_out("t1.pres", 1'b1, 3'd2, 8'h04, 1'b0);
    ack = 1'b1; tick(); ack = 1'b0;
    check_out("t1.ack", 1'b0, 3'd0, 8'h00, 1'b0);

    // 2: back-to-back codes under continuous ack
    req = 8'b1001_0010; tick(); req = 8'h00;
    check_out("t2.c7", 1'b1, 3'd7, 8'h92, 1'b0);
    ack = 1'b1;
    tick(); check_out("t2.c4", 1'b1, 3'd4, 8'h12, 1'b0);
    tick(); check_out("t2.c1", 1'b1, 3'd1, 8'h02, 1'b0);
    tick(); check_out("t2.end", 1'b0, 3'd0, 8'h00, 1'b0);
    ack = 1'b0;

    // ack while idle is ignored
    ack = 1'b1; tick(); ack = 1'b0;
    check_out("idle_ack", 1'b0, 3'd0, 8'h00, 1'b0);

    // 3: no preemption by higher-priority arrival
    req = 8'h02; tick(); req = 8'h00;
    check_out("t3.c1", 1'b1, 3'd1, 8'h02, 1'b0);
    req = 8'h40; tick(); req = 8'h00;
    check_out("t3.hold", 1'b1, 3'd1, 8'h42, 1'b0);
    tick(); check_out("t3.hold2", 1'b1, 3'd1, 8'h42, 1'b0);
    ack = 1'b1; tick();
    check_out("t3.c6", 1'b1, 3'd6, 8'h40, 1'b0);
    tick(); ack = 1'b0;
    check_out("t3.end", 1'b0, 3'd0, 8'h00, 1'b0);

    // 4: drop on collision, then requeue when colliding with ack
    req = 8'h20; tick(); req = 8'h00;
    check_out("t4.c5", 1'b1, 3'd5, 8'h20, 1'b0);
    req = 8'h20; tick(); req = 8'h00;
    check_out("t4.drop", 1'b1, 3'd5, 8'h20, 1'b1);
    tick(); check_out("t4.drop_off", 1'b1, 3'd5, 8'h20, 1'b0);
    req = 8'h20; ack = 1'b1; tick(); req = 8'h00; ack = 1'b0;
    check_out("t4.requeue", 1'b1, 3'd5, 8'h20, 1'b0);
    ack = 1'b1; tick(); ack = 1'b0;
    check_out("t4.end", 1'b0, 3'd0, 8'h00, 1'b0);

    // 5: capture disabled, then enabled; drain all eight codes
    en = 1'b0; req = 8'hFF;
    tick(); check_out("t5.dis0", 1'b0, 3'd0, 8'h00, 1'b0);
    tick(); check_out("t5.dis1", 1'b0, 3'd0, 8'h00, 1'b0);
    en = 1'b1; tick(); req = 8'h00;
    check_out("t5.c7", 1'b1, 3'd7, 8'hFF, 1'b0);
    ack = 1'b1;
    for (int i = 6; i >= 0; i--) begin
      tick();
      check_out("t5.drain", 1'b1, 3'(i), 8'((16'h1 << (i + 1)) - 1), 1'b0);
    end
    tick(); ack = 1'b0;
    check_out("t5.end", 1'b0, 3'd0, 8'h00, 1'b0);

    // en=0 does not block ack clears of an in-flight presentation
    req = 8'h09; tick(); req = 8'h00;
    check_out("t5b.c3", 1'b1, 3'd3, 8'h09, 1'b0);
    en = 1'b0; req = 8'h09; ack = 1'b1; tick(); req = 8'h00;
    check_out("t5b.c0", 1'b1, 3'd0, 8'h01, 1'b0);
    tick(); ack = 1'b0; en = 1'b1;
    check_out("t5b.end", 1'b0, 3'd0, 8'h00, 1'b0);

    // 6: asynchronous reset mid-presentation
    req = 8'h18; tick(); req = 8'h00;
    check_out("t6.c4", 1'b1, 3'd4, 8'h18, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_vec("t6.rst.code", 32'(code), 32'd0);
    check_out("t6.rst", 1'b0, 3'd0, 8'h00, 1'b0);
    #2 rst_n = 1'b1;
    tick(); check_out("t6.post0", 1'b0, 3'd0, 8'h00, 1'b0);
    tick(); check_out("t6.post1", 1'b0, 3'd0, 8'h00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
